instr_fetch_unit: RTL

Front end of the single-cycle ARM-subset processor. Holds the PC and fetches 32-bit instructions from instruction memory over a req/ack handshake. Splits each instruction into the Cond/Op/Funct/Rd/Rn fields that the control unit consumes, and presents them with a valid/ready handshake. Takes the control unit's PCSrc decision and the branch/write-back target back to form the next PC, so it is the producer end of the control unit's input interface.

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/fetch_timeout_counter.sv | 29 ++
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Covers FSM states, fault codes, instruction field positions and PC arithmetic steps.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_TIMEOUT  = 2'b01;
  localparam logic [1:0] FLT_MISALIGN = 2'b10;

  localparam int COND_HI  = 31;
  localparam int COND_LO  = 28;
  localparam int OP_HI    = 27;
  localparam int OP_LO    = 26;
  localparam int FUNCT_HI = 25;
  localparam int FUNCT_LO = 20;
  localparam int RN_HI    = 19;
  localparam int RN_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 12;

  localparam logic [31:0] PC_STEP       = 32'd4;
  localparam logic [31:0] PC_R15_OFFSET = 32'd8;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts FETCH cycles without an ack.
// Expires once the count reaches ACK_TIMEOUT-1, then saturates.
module fetch_timeout_counter
  import fetch_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [7:0] LIMIT = 8'(ACK_TIMEOUT - 1);

  logic [7:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= 8'd0;
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/instr_fetch_unit.sv
// PC holder and instruction fetcher: req/ack toward memory, valid/ready toward the control unit.
// Handshakes: imem_ack counts only in FETCH; an instruction is accepted on a cycle with instr_valid && instr_ready.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic [3:0]  cond,
  output logic [1:0]  op,
  output logic [5:0]  funct,
  output logic [3:0]  rn,
  output logic [3:0]  rd,
  output logic [31:0] pc,
  output logic [31:0] pc_plus8,
  output logic        fault,
  output logic [1:0]  fault_code,
  output state_t      o_dbg_state
);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] r_instr;
  logic [1:0]  r_fault_code;
  logic [1:0]  w_fault_code_next;
  logic        w_load_instr;
  logic        w_tmo_clear;
  logic        w_tmo_enable;
  logic        w_tmo_expired;

  // The counter only runs across consecutive un-acked FETCH cycles.
  assign w_tmo_clear  = (r_state != FETCH) || imem_ack;
  assign w_tmo_enable = (r_state == FETCH) && !imem_ack;

  fetch_timeout_counter #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_tmo_clear),
    .i_enable (w_tmo_enable),
    .o_expired(w_tmo_expired)
  );

  always_comb begin
    w_next_state      = r_state;
    w_pc_next         = r_pc;
    w_fault_code_next = r_fault_code;
    w_load_instr      = 1'b0;
    case (r_state)
      IDLE: w_next_state = FETCH;
      FETCH: begin
        // Ack takes priority over a timeout in the same cycle.
        if (imem_ack) begin
          w_load_instr = 1'b1;
          w_next_state = ISSUE;
        end else if (w_tmo_expired) begin
          w_fault_code_next = FLT_TIMEOUT;
          w_next_state      = FAULT;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          if (!pc_src) begin
            w_pc_next    = r_pc + PC_STEP;
            w_next_state = FETCH;
          end else if (branch_target[1:0] == 2'b00) begin
            w_pc_next    = branch_target;
            w_next_state = FETCH;
          end else begin
            w_fault_code_next = FLT_MISALIGN;
            w_next_state      = FAULT;
          end
        end
      end
      FAULT: w_next_state = FAULT;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_instr      <= 32'd0;
      r_fault_code <= FLT_NONE;
    end else begin
      r_state      <= w_next_state;
      r_pc         <= w_pc_next;
      r_fault_code <= w_fault_code_next;
      if (w_load_instr) begin
        r_instr <= imem_rdata;
      end
    end
  end

  assign imem_req    = (r_state == FETCH);
  assign imem_addr   = r_pc;
  assign instr_valid = (r_state == ISSUE);
  assign instr       = r_instr;
  assign cond        = r_instr[COND_HI:COND_LO];
  assign op          = r_instr[OP_HI:OP_LO];
  assign funct       = r_instr[FUNCT_HI:FUNCT_LO];
  assign rn          = r_instr[RN_HI:RN_LO];
  assign rd          = r_instr[RD_HI:RD_LO];
  assign pc          = r_pc;
  assign pc_plus8    = r_pc + PC_R15_OFFSET;
  assign fault       = (r_state == FAULT);
  assign fault_code  = r_fault_code;
  assign o_dbg_state = r_state;

endmodule
